// File: rtl/disp_pack_pkg.sv
// Shared constants and FSM encoding for the disparity output packer.
// Default geometry matches the median-filter output path.
package disp_pack_pkg;

    localparam int DEF_WIDTH = 9;
    localparam int DEF_PACK  = 4;
    localparam int DEF_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pack_state_e;

endpackage

// File: rtl/disp_pack_fifo.sv
// First-word-fall-through FIFO holding packed words plus their last/eof tags.
// Head entry is presented combinationally and reads as zero while empty.
module disp_pack_fifo
    import disp_pack_pkg::*;
#(
    parameter int DW    = DEF_PACK * DEF_WIDTH + 2,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [DW-1:0] pushData_i,
    input  logic          pop_i,
    output logic [DW-1:0] popData_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wrPtr_q, wrPtr_d;
    logic [AW:0]   rdPtr_q, rdPtr_d;
    logic          doWrite, doRead;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

    // A pop frees the head slot in the same edge, so a full FIFO can still take a push.
    assign doWrite = push_i && (!full_o || pop_i);
    assign doRead  = pop_i && !empty_o;

    assign popData_o = empty_o ? '0 : mem[rdPtr_q[AW-1:0]];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (doWrite) wrPtr_d = wrPtr_q + 1'b1;
        if (doRead)  rdPtr_d = rdPtr_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (doWrite) mem[wrPtr_q[AW-1:0]] <= pushData_i;
    end

endmodule

// File: rtl/disp_out_packer.sv
// Packs PACK disparity pixels per output word with line/frame tagging,
// buffered through a FWFT FIFO toward a valid/ready consumer.
module disp_out_packer
    import disp_pack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PACK  = DEF_PACK,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clken,
    input  logic                  enable,
    input  logic [10:0]           width,
    input  logic [WIDTH-1:0]      disp,
    input  logic                  valid_final,
    input  logic                  flag,
    output logic [PACK*WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  m_eof,
    output logic                  overflow
);

    localparam int WORD_W = PACK * WIDTH;
    localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;

    pack_state_e       state_q, state_d;
    logic              enPrev_q;
    logic [10:0]       widthLat_q, widthLat_d;
    logic [10:0]       colCnt_q, colCnt_d;
    logic [LANE_W-1:0] laneCnt_q, laneCnt_d;
    logic [WORD_W-1:0] stage_q, stage_d;
    logic              overflow_q, overflow_d;

    logic              enRise, endLine, lastLane;
    logic [WORD_W-1:0] laneWord;
    logic              push, pop, fifoFull, fifoEmpty;
    logic [WORD_W+1:0] pushWord, popWord;

    assign enRise   = enable && !enPrev_q;
    assign endLine  = (colCnt_q == widthLat_q - 11'd1);
    assign lastLane = (laneCnt_q == LANE_W'(PACK - 1));
    assign pop      = !fifoEmpty && m_ready;

    always_comb begin
        state_d    = state_q;
        widthLat_d = widthLat_q;
        colCnt_d   = colCnt_q;
        laneCnt_d  = laneCnt_q;
        stage_d    = stage_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        pushWord   = '0;
        laneWord   = stage_q;

        for (int i = 0; i < PACK; i++) begin
            if (laneCnt_q == LANE_W'(i)) laneWord[i*WIDTH +: WIDTH] = disp;
        end

        case (state_q)
            IDLE: begin
                if (enRise) begin
                    state_d    = RUN;
                    widthLat_d = (width == 11'd0) ? 11'd1 : width;
                    colCnt_d   = '0;
                    laneCnt_d  = '0;
                    stage_d    = '0;
                end
            end
            RUN: begin
                // Losing enable flushes any partial word untagged; a pixel on that cycle is dropped.
                if (!enable) begin
                    state_d   = DRAIN;
                    push      = (laneCnt_q != '0);
                    pushWord  = {2'b00, stage_q};
                    laneCnt_d = '0;
                    stage_d   = '0;
                end else if (clken && valid_final) begin
                    if (lastLane || endLine || flag) begin
                        push      = 1'b1;
                        pushWord  = {flag, endLine || flag, laneWord};
                        laneCnt_d = '0;
                        stage_d   = '0;
                        colCnt_d  = (endLine || flag) ? 11'd0 : colCnt_q + 11'd1;
                    end else begin
                        laneCnt_d = laneCnt_q + 1'b1;
                        stage_d   = laneWord;
                        colCnt_d  = colCnt_q + 11'd1;
                    end
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (enRise)
            overflow_d = 1'b0;
        else if (push && fifoFull && !pop)
            overflow_d = 1'b1;
    end

    // enPrev resets high so an enable already held through reset is not seen as a new edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            enPrev_q   <= 1'b1;
            widthLat_q <= 11'd1;
            colCnt_q   <= '0;
            laneCnt_q  <= '0;
            stage_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            enPrev_q   <= enable;
            widthLat_q <= widthLat_d;
            colCnt_q   <= colCnt_d;
            laneCnt_q  <= laneCnt_d;
            stage_q    <= stage_d;
            overflow_q <= overflow_d;
        end
    end

    disp_pack_fifo #(
        .DW    (WORD_W + 2),
        .DEPTH (DEPTH)
    ) uFifo (
        .clk_i      (clk),
        .rst_ni     (rst),
        .push_i     (push),
        .pushData_i (pushWord),
        .pop_i      (pop),
        .popData_o  (popWord),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

    assign m_valid  = !fifoEmpty;
    assign m_eof    = popWord[WORD_W+1];
    assign m_last   = popWord[WORD_W];
    assign m_data   = popWord[WORD_W-1:0];
    assign overflow = overflow_q;

endmodule

// File: tb/tb_disp_out_packer.sv
// Directed bench for disp_out_packer: packing, line/frame tags, overflow,
// backpressure stability, enable drop and mid-run reset.
module tb_disp_out_packer;

    localparam int W  = 9;
    localparam int P  = 4;
    localparam int D  = 16;
    localparam int WW = P * W + 2;

    logic          clk = 1'b0;
    logic          rst, clken, enable, valid_final, flag, m_ready;
    logic [10:0]   width;
    logic [W-1:0]  disp;
    logic [P*W-1:0] m_data;
    logic          m_valid, m_last, m_eof, overflow;

    int total = 0;
    int bad   = 0;

    logic [WW-1:0] words[$];
    logic          stallPrev = 1'b0;
    logic [WW-1:0] prevWord  = '0;

    disp_out_packer #(.WIDTH(W), .PACK(P), .DEPTH(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .clken       (clken),
        .enable      (enable),
        .width       (width),
        .disp        (disp),
        .valid_final (valid_final),
        .flag        (flag),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .m_eof       (m_eof),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Captures transfers and checks the head word holds while the consumer stalls.
    always @(negedge clk) begin
        if (!rst) begin
            stallPrev = 1'b0;
        end else begin
            if (stallPrev && m_valid) checkOutput("stable", {m_eof, m_last, m_data}, prevWord);
            if (m_valid && m_ready) words.push_back({m_eof, m_last, m_data});
            stallPrev = m_valid && !m_ready;
            prevWord  = {m_eof, m_last, m_data};
        end
    end

    function automatic logic [WW-1:0] ew(input bit eof, input bit last, input int a, input int b,
                                         input int c, input int d);
        return {eof, last, W'(d), W'(c), W'(b), W'(a)};
    endfunction

    function automatic logic [WW-1:0] peek(input int idx);
        if (idx < words.size()) return words[idx];
        return '1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int pix, input bit fl);
        disp        = W'(pix);
        flag        = fl;
        valid_final = 1'b1;
        clken       = 1'b1;
        tick(1);
    endtask

    task automatic idleInputs();
        valid_final = 1'b0;
        flag        = 1'b0;
    endtask

    task automatic startRun(input int w);
        enable = 1'b0;
        tick(1);
        width  = 11'(w);
        enable = 1'b1;
        tick(1);
    endtask

    task automatic stopRun();
        idleInputs();
        enable = 1'b0;
        tick(2);
    endtask

    task automatic waitWords(input int n, input int budget);
        int c = 0;
        while (words.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        if (words.size() < n) checkOutput("timeout", words.size(), n);
    endtask

    initial begin
        rst = 1'b0; clken = 1'b0; enable = 1'b0; valid_final = 1'b0;
        flag = 1'b0; m_ready = 1'b1; width = '0; disp = '0;

        #12;
        checkOutput("rst m_valid", m_valid, 0);
        checkOutput("rst m_data", m_data, 0);
        checkOutput("rst m_last", m_last, 0);
        checkOutput("rst m_eof", m_eof, 0);
        checkOutput("rst overflow", overflow, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        tick(1);

        // One 10-pixel line, with a clken-low cycle that must not be sampled.
        startRun(10);
        for (int i = 0; i < 5; i++) applyStimulus(i, 0);
        disp = W'(99); clken = 1'b0; tick(1);
        for (int i = 5; i < 10; i++) applyStimulus(i, 0);
        idleInputs();
        waitWords(3, 20);
        tick(3);
        checkOutput("line count", words.size(), 3);
        checkOutput("line w0", peek(0), ew(0, 0, 0, 1, 2, 3));
        checkOutput("line w1", peek(1), ew(0, 0, 4, 5, 6, 7));
        checkOutput("line w2", peek(2), ew(0, 1, 8, 9, 0, 0));
        stopRun();
        words.delete();

        // Frame end via flag, then a full line proving the column count restarted.
        startRun(8);
        for (int i = 0; i < 5; i++) applyStimulus(i, 0);
        applyStimulus(5, 1);
        for (int i = 0; i < 8; i++) applyStimulus(i, 0);
        idleInputs();
        waitWords(4, 20);
        tick(3);
        checkOutput("flag count", words.size(), 4);
        checkOutput("flag w0", peek(0), ew(0, 0, 0, 1, 2, 3));
        checkOutput("flag w1", peek(1), ew(1, 1, 4, 5, 0, 0));
        checkOutput("flag w2", peek(2), ew(0, 0, 0, 1, 2, 3));
        checkOutput("flag w3", peek(3), ew(0, 1, 4, 5, 6, 7));
        stopRun();
        words.delete();

        // width of zero behaves as one pixel per line.
        startRun(0);
        applyStimulus(7, 0);
        applyStimulus(8, 0);
        idleInputs();
        waitWords(2, 20);
        checkOutput("w0 count", words.size(), 2);
        checkOutput("w0 p7", peek(0), ew(0, 1, 7, 0, 0, 0));
        checkOutput("w0 p8", peek(1), ew(0, 1, 8, 0, 0, 0));
        stopRun();
        words.delete();

        // Enable drops after 6 pixels; trailing pixels must be ignored.
        startRun(100);
        for (int i = 0; i < 6; i++) applyStimulus(i, 0);
        enable = 1'b0;
        for (int i = 20; i < 24; i++) applyStimulus(i, 0);
        idleInputs();
        tick(6);
        checkOutput("drop count", words.size(), 2);
        checkOutput("drop w0", peek(0), ew(0, 0, 0, 1, 2, 3));
        checkOutput("drop w1", peek(1), ew(0, 0, 4, 5, 0, 0));
        words.delete();

        // Overflow: 18 words into a 16-deep FIFO with the consumer stalled.
        m_ready = 1'b0;
        startRun(1920);
        for (int i = 0; i < 72; i++) applyStimulus(i, 0);
        idleInputs();
        checkOutput("ovf flag", overflow, 1);
        checkOutput("ovf valid", m_valid, 1);
        checkOutput("ovf held", words.size(), 0);
        stopRun();
        checkOutput("ovf sticky", overflow, 1);
        m_ready = 1'b1;
        waitWords(16, 40);
        tick(5);
        checkOutput("ovf drained", words.size(), 16);
        checkOutput("ovf first", peek(0), ew(0, 0, 0, 1, 2, 3));
        checkOutput("ovf last", peek(15), ew(0, 0, 60, 61, 62, 63));
        checkOutput("ovf empty", m_valid, 0);
        startRun(1920);
        checkOutput("ovf cleared", overflow, 0);
        stopRun();
        words.delete();

        // Consumer toggles ready every cycle across a 16-pixel line.
        m_ready = 1'b0;
        startRun(16);
        for (int i = 0; i < 16; i++) begin
            m_ready = ~m_ready;
            applyStimulus(100 + i, 0);
        end
        idleInputs();
        for (int c = 0; c < 40 && words.size() < 4; c++) begin
            m_ready = ~m_ready;
            tick(1);
        end
        m_ready = 1'b1;
        tick(4);
        checkOutput("tog count", words.size(), 4);
        checkOutput("tog w0", peek(0), ew(0, 0, 100, 101, 102, 103));
        checkOutput("tog w1", peek(1), ew(0, 0, 104, 105, 106, 107));
        checkOutput("tog w2", peek(2), ew(0, 0, 108, 109, 110, 111));
        checkOutput("tog w3", peek(3), ew(0, 1, 112, 113, 114, 115));
        stopRun();
        words.delete();

        // Reset with 5 queued words; enable held high must not restart the run.
        m_ready = 1'b0;
        startRun(1920);
        for (int i = 0; i < 20; i++) applyStimulus(i, 0);
        idleInputs();
        checkOutput("rst q valid", m_valid, 1);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        checkOutput("rst async valid", m_valid, 0);
        checkOutput("rst async data", m_data, 0);
        tick(2);
        rst = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus(i, 0);
        idleInputs();
        tick(5);
        checkOutput("rst no words", words.size(), 0);
        checkOutput("rst idle valid", m_valid, 0);
        stopRun();
        startRun(4);
        for (int i = 0; i < 4; i++) applyStimulus(i + 1, 0);
        idleInputs();
        waitWords(1, 20);
        checkOutput("rst rerun", peek(0), ew(0, 1, 1, 2, 3, 4));
        stopRun();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
